// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder
//   Pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups.
//   Each pipeline stage resolves GROUPS_PER_STAGE groups. The carry between
//   stages is registered, and the unprocessed upper operand slices travel
//   down the pipe with the partial result (operand skew).
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready input handshake (in_ready = global advance)
//   a, b, c_in, sub   operands; sub=1 computes a-b and ignores c_in
//   out_valid/out_ready output handshake
//   s, c_out          sum/difference and carry out of the MSB
//   overflow, zero    signed overflow, s==0
//   g_out, p_out      word-level generate / propagate for cascading
//
// cla_slice
//   Combinational block for one stage. It runs GPS 4-bit CLA groups, uses
//   group-level lookahead for the inter-group carries, and produces the
//   stage G/P.
// ---------------------------------------------------------------------------

module cla_slice #(
    parameter int GPS = 2
) (
    input  logic [4*GPS-1:0] a,
    input  logic [4*GPS-1:0] b,
    input  logic             cin,
    output logic [4*GPS-1:0] sum,
    output logic             cout,
    output logic             cmsb,
    output logic             grp_g,
    output logic             grp_p
);
    localparam int SW = 4 * GPS;

    // Carries into bits 0..3 of one group, fully expanded lookahead terms.
    function automatic logic [3:0] cla4_carry(input logic [3:0] g, input logic [3:0] p,
                                              input logic c);
        logic [3:0] cc;
        cc[0] = c;
        cc[1] = g[0] | (p[0] & c);
        cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        return cc;
    endfunction

    // Group generate: the group produces a carry on its own.
    function automatic logic cla4_gen(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    logic [SW-1:0]  g_s;
    logic [SW-1:0]  p_s;
    logic [SW-1:0]  c_s;
    logic [GPS-1:0] gg_s;
    logic [GPS-1:0] pp_s;
    logic [GPS:0]   cg_s;
    logic           term_s;
    logic           gen_s;

    // Bit, group and stage lookahead. Each group carry is written as an
    // expanded sum of products over the lower groups, so no carry ripples.
    always_comb begin
        g_s    = a & b;
        p_s    = a ^ b;
        gg_s   = '0;
        pp_s   = '0;
        cg_s   = '0;
        c_s    = '0;
        term_s = 1'b0;
        gen_s  = 1'b0;
        for (int i = 0; i < GPS; i++) begin
            gg_s[i] = cla4_gen(g_s[4*i +: 4], p_s[4*i +: 4]);
            pp_s[i] = &p_s[4*i +: 4];
        end
        for (int i = 0; i <= GPS; i++) begin
            cg_s[i] = cin;
            for (int j = 0; j < i; j++) begin
                cg_s[i] = cg_s[i] & pp_s[j];
            end
            for (int j = 0; j < i; j++) begin
                term_s = gg_s[j];
                for (int m = j + 1; m < i; m++) begin
                    term_s = term_s & pp_s[m];
                end
                cg_s[i] = cg_s[i] | term_s;
            end
        end
        for (int j = 0; j < GPS; j++) begin
            term_s = gg_s[j];
            for (int m = j + 1; m < GPS; m++) begin
                term_s = term_s & pp_s[m];
            end
            gen_s = gen_s | term_s;
        end
        for (int i = 0; i < GPS; i++) begin
            c_s[4*i +: 4] = cla4_carry(g_s[4*i +: 4], p_s[4*i +: 4], cg_s[i]);
        end
    end

    assign sum   = p_s ^ c_s;
    assign cout  = cg_s[GPS];
    assign cmsb  = c_s[SW-1];
    assign grp_g = gen_s;
    assign grp_p = &pp_s;
endmodule

module cla_pipe_adder #(
    parameter int WIDTH            = 32,
    parameter int GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             overflow,
    output logic             zero,
    output logic             g_out,
    output logic             p_out
);
    localparam int SW     = 4 * GROUPS_PER_STAGE;
    localparam int STAGES = (GROUPS_PER_STAGE > 0) ? (WIDTH / (4 * GROUPS_PER_STAGE)) : 1;

    if ((GROUPS_PER_STAGE < 1) || (WIDTH < 4 * GROUPS_PER_STAGE) ||
        ((WIDTH % (4 * GROUPS_PER_STAGE)) != 0)) begin : g_bad_params
        $error("cla_pipe_adder: WIDTH must be a positive multiple of 4*GROUPS_PER_STAGE");
    end

    // Stage registers
    logic             valid_r [STAGES];
    logic [WIDTH-1:0] sum_r   [STAGES];
    logic             carry_r [STAGES];
    logic             gg_r    [STAGES];
    logic             pp_r    [STAGES];
    logic [WIDTH-1:0] rem_a_r [STAGES];
    logic [WIDTH-1:0] rem_b_r [STAGES];
    logic             ovf_r;
    logic             zero_r;

    // Stage inputs: ports for stage 0, previous stage register otherwise
    logic             in_v_s   [STAGES];
    logic [WIDTH-1:0] in_a_s   [STAGES];
    logic [WIDTH-1:0] in_b_s   [STAGES];
    logic             in_c_s   [STAGES];
    logic [WIDTH-1:0] in_sum_s [STAGES];
    logic             in_g_s   [STAGES];
    logic             in_p_s   [STAGES];

    // Slice outputs and next-state values
    logic [SW-1:0]    sl_sum_s  [STAGES];
    logic             sl_cout_s [STAGES];
    logic             sl_cmsb_s [STAGES];
    logic             sl_g_s    [STAGES];
    logic             sl_p_s    [STAGES];
    logic [WIDTH-1:0] nxt_sum_s [STAGES];
    logic             nxt_g_s   [STAGES];
    logic             nxt_p_s   [STAGES];

    logic advance_s;

    // The whole pipe moves together; a full output that is not taken freezes it.
    assign advance_s = !valid_r[STAGES-1] || out_ready;
    assign in_ready  = advance_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Subtraction is a + ~b + 1, so the carry is forced to 1 and c_in is ignored.
            assign in_v_s[k]   = in_valid;
            assign in_a_s[k]   = a;
            assign in_b_s[k]   = b ^ {WIDTH{sub}};
            assign in_c_s[k]   = sub | c_in;
            assign in_sum_s[k] = {WIDTH{1'b0}};
            assign in_g_s[k]   = 1'b0;
            assign in_p_s[k]   = 1'b1;
        end else begin : g_next
            assign in_v_s[k]   = valid_r[k-1];
            assign in_a_s[k]   = rem_a_r[k-1];
            assign in_b_s[k]   = rem_b_r[k-1];
            assign in_c_s[k]   = carry_r[k-1];
            assign in_sum_s[k] = sum_r[k-1];
            assign in_g_s[k]   = gg_r[k-1];
            assign in_p_s[k]   = pp_r[k-1];
        end

        // The remaining operands are kept right-aligned, so each stage
        // always works on the low SW bits.
        cla_slice #(.GPS(GROUPS_PER_STAGE)) u_slice (
            .a     (in_a_s[k][SW-1:0]),
            .b     (in_b_s[k][SW-1:0]),
            .cin   (in_c_s[k]),
            .sum   (sl_sum_s[k]),
            .cout  (sl_cout_s[k]),
            .cmsb  (sl_cmsb_s[k]),
            .grp_g (sl_g_s[k]),
            .grp_p (sl_p_s[k])
        );

        // The bits above this slice are still zero, so the new slice is OR-ed into place.
        assign nxt_sum_s[k] = in_sum_s[k] | (WIDTH'(sl_sum_s[k]) << (k * SW));
        // Word G/P accumulate upwards: this slice sits above everything already seen.
        assign nxt_g_s[k]   = sl_g_s[k] | (sl_p_s[k] & in_g_s[k]);
        assign nxt_p_s[k]   = sl_p_s[k] & in_p_s[k];
    end

    // Pipeline registers: load on advance, hold on stall, clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_r[k] <= 1'b0;
                sum_r[k]   <= {WIDTH{1'b0}};
                carry_r[k] <= 1'b0;
                gg_r[k]    <= 1'b0;
                pp_r[k]    <= 1'b0;
                rem_a_r[k] <= {WIDTH{1'b0}};
                rem_b_r[k] <= {WIDTH{1'b0}};
            end
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (advance_s) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_r[k] <= in_v_s[k];
                sum_r[k]   <= nxt_sum_s[k];
                carry_r[k] <= sl_cout_s[k];
                gg_r[k]    <= nxt_g_s[k];
                pp_r[k]    <= nxt_p_s[k];
                rem_a_r[k] <= in_a_s[k] >> SW;
                rem_b_r[k] <= in_b_s[k] >> SW;
            end
            // Overflow compares the carry into the MSB with the carry out of it.
            ovf_r  <= sl_cmsb_s[STAGES-1] ^ sl_cout_s[STAGES-1];
            zero_r <= (nxt_sum_s[STAGES-1] == {WIDTH{1'b0}});
        end
    end

    assign out_valid = valid_r[STAGES-1];
    assign s         = sum_r[STAGES-1];
    assign c_out     = carry_r[STAGES-1];
    assign g_out     = gg_r[STAGES-1];
    assign p_out     = pp_r[STAGES-1];
    assign overflow  = ovf_r;
    assign zero      = zero_r;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_pipe_adder
//   Directed bench for cla_pipe_adder with WIDTH=32 and GROUPS_PER_STAGE=2,
//   giving 4 stages. Results are packed as {s, c_out, overflow, zero, g_out, p_out}.
// ---------------------------------------------------------------------------

module tb_cla_pipe_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        c_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        c_out;
    logic        overflow;
    logic        zero;
    logic        g_out;
    logic        p_out;

    int n_cmp = 0;
    int n_bad = 0;

    cla_pipe_adder #(.WIDTH(32), .GROUPS_PER_STAGE(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .c_out(c_out), .overflow(overflow), .zero(zero),
        .g_out(g_out), .p_out(p_out)
    );

    always #5 clk = ~clk;

    function automatic logic [36:0] result_vec();
        return {s, c_out, overflow, zero, g_out, p_out};
    endfunction

    // Arithmetic reference model: 33-bit addition with the operand conditioned for sub.
    function automatic logic [36:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mc, input logic ms);
        logic [31:0] bb;
        logic [32:0] sum33;
        logic [32:0] gen33;
        logic        ovf;
        bb    = mb ^ {32{ms}};
        sum33 = {1'b0, ma} + {1'b0, bb} + {32'd0, (ms | mc)};
        gen33 = {1'b0, ma} + {1'b0, bb};
        ovf   = (ma[31] == bb[31]) && (sum33[31] != ma[31]);
        return {sum33[31:0], sum33[32], ovf, (sum33[31:0] == 32'd0), gen33[32], &(ma ^ bb)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One isolated beat: check the latency of 3 edges after accept, then the result.
    task automatic single(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tc, input logic ts, input logic [36:0] exp);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb; c_in = tc; sub = ts;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd3);
        check({tag, " result"}, 64'(result_vec()), 64'(exp));
        @(posedge clk); #1;
    endtask

    // Random stream against a scoreboard; bp selects random output backpressure.
    task automatic stream(input string tag, input int nbeats, input bit bp);
        logic [36:0] q[$];
        logic [36:0] held;
        logic        was_stalled;
        int          sent;
        int          got;
        int          cyc;
        int          first;
        int          last;
        sent = 0; got = 0; cyc = 0; first = -1; last = -1;
        was_stalled = 1'b0;
        held = 37'd0;
        while ((sent < nbeats || got < nbeats) && cyc < 2000) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < nbeats) begin
                in_valid = 1'b1;
                a = $urandom; b = $urandom;
                c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check({tag, " in_ready"}, 64'(in_ready), 64'(!out_valid || out_ready));
            if (was_stalled) begin
                check({tag, " held valid"}, 64'(out_valid), 64'd1);
                check({tag, " held data"}, 64'(result_vec()), 64'(held));
            end
            if (out_valid && out_ready) begin
                check({tag, " beat expected"}, 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    check({tag, " result"}, 64'(result_vec()), 64'(q.pop_front()));
                end
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            was_stalled = out_valid && !out_ready;
            held = result_vec();
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, c_in, sub));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " received"}, 64'(got), 64'(nbeats));
        check({tag, " leftover"}, 64'(q.size()), 64'd0);
        if (!bp) begin
            check({tag, " back-to-back span"}, 64'(last - first), 64'(nbeats - 1));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int stale;
        rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0;
        c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset outputs", 64'(result_vec()), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Result packing: {s, c_out, overflow, zero, g_out, p_out}
        single("add 4+2",      32'h4,        32'h2,        1'b0, 1'b0, {32'h6,        5'b00000});
        single("wrap cin",     32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, {32'h0,        5'b10101});
        single("wrap b1",      32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, {32'h0,        5'b10110});
        single("sub min-1",    32'h80000000, 32'h1,        1'b0, 1'b1, {32'h7FFFFFFF, 5'b11010});
        single("sub 3-5",      32'h3,        32'h5,        1'b0, 1'b1, {32'hFFFFFFFE, 5'b00000});
        single("sub cin ign",  32'hA,        32'h3,        1'b1, 1'b1, {32'h7,        5'b10010});
        single("pos ovf",      32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, {32'h80000000, 5'b01000});
        single("stage carry",  32'h0000FFFF, 32'h1,        1'b0, 1'b0, {32'h00010000, 5'b00000});
        single("stage carry2", 32'h00FFFFFF, 32'h1,        1'b0, 1'b0, {32'h01000000, 5'b00000});

        stream("stream", 16, 1'b0);
        stream("backpressure", 24, 1'b1);

        // Four beats accepted with the output blocked; the first reaches the output.
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; a = 32'(i); b = 32'(i); c_in = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("pre-reset out_valid", 64'(out_valid), 64'd1);
        check("pre-reset s", 64'(s), 64'd2);
        check("pre-reset in_ready", 64'(in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async reset out_valid", 64'(out_valid), 64'd0);
        check("async reset outputs", 64'(result_vec()), 64'd0);
        check("async reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        single("post-reset", 32'h12345678, 32'h11111111, 1'b0, 1'b0, {32'h23456789, 5'b00000});
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no stale beats", 64'(stale), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
